// File: rtl/unidade_memoria_dados.sv
// rtl/unidade_memoria_dados.sv - handshaked little-endian data memory with fixed response latency
module unidade_memoria_dados #(
   parameter int PROFUNDIDADE_BYTES = 128,
   parameter int LATENCIA           = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valido,
   output logic        req_pronto,
   input  logic        req_escrita,
   input  logic [1:0]  req_tamanho,
   input  logic        req_sinal,
   input  logic [31:0] req_endereco,
   input  logic [31:0] req_dado,
   output logic        resp_valido,
   output logic [31:0] resp_dado,
   output logic        resp_erro,
   output logic        ocupado
);

   localparam int AW = $clog2(PROFUNDIDADE_BYTES);

   typedef enum logic [1:0] {
      OCIOSO,
      ESPERA,
      RESPOSTA
   } estado_t;

   estado_t estado_q, estado_d;
   logic [2:0]    cnt_q, cnt_d;

   logic          escrita_q;
   logic [1:0]    tamanho_q;
   logic          sinal_q;
   logic [AW-1:0] base_q;
   logic [31:0]   dado_q;
   logic          erro_q;

   logic [7:0]    memoria [0:PROFUNDIDADE_BYTES-1];

   logic [31:0]   resp_dado_q, resp_dado_d;
   logic          resp_erro_q;

   logic          aceita;
   logic          commit;
   logic [1:0]    off_in;
   logic [32:0]   fim_in;
   logic          erro_in;

   logic          usa_entrada;
   logic          src_escrita;
   logic [1:0]    src_tamanho;
   logic          src_sinal;
   logic [AW-1:0] src_base;
   logic [31:0]   src_dado;
   logic          src_erro;
   logic [1:0]    src_off;
   logic [AW-1:0] idx [4];
   logic [31:0]   lido;

   assign req_pronto  = (estado_q == OCIOSO);
   assign ocupado     = (estado_q != OCIOSO);
   assign resp_valido = (estado_q == RESPOSTA);
   assign resp_dado   = resp_dado_q;
   assign resp_erro   = resp_erro_q;

   assign aceita = req_valido & req_pronto;
   assign commit = (estado_d == RESPOSTA);

   // Offset of the last byte touched; the range check uses the full 32-bit address.
   always_comb begin
      off_in = 2'd0;
      case (req_tamanho)
         2'b00:   off_in = 2'd0;
         2'b01:   off_in = 2'd1;
         default: off_in = 2'd3;
      endcase
      fim_in  = {1'b0, req_endereco} + {31'b0, off_in};
      erro_in = (req_tamanho == 2'b11)
              | ((req_tamanho == 2'b01) & req_endereco[0])
              | ((req_tamanho == 2'b10) & (req_endereco[1:0] != 2'b00))
              | (fim_in >= 33'(PROFUNDIDADE_BYTES));
   end

   // With LATENCIA=1 the commit edge is also the accept edge, so take fields from the inputs.
   assign usa_entrada = (estado_q == OCIOSO);
   assign src_escrita = usa_entrada ? req_escrita          : escrita_q;
   assign src_tamanho = usa_entrada ? req_tamanho          : tamanho_q;
   assign src_sinal   = usa_entrada ? req_sinal            : sinal_q;
   assign src_base    = usa_entrada ? req_endereco[AW-1:0] : base_q;
   assign src_dado    = usa_entrada ? req_dado             : dado_q;
   assign src_erro    = usa_entrada ? erro_in              : erro_q;

   always_comb begin
      src_off = 2'd3;
      case (src_tamanho)
         2'b00:   src_off = 2'd0;
         2'b01:   src_off = 2'd1;
         default: src_off = 2'd3;
      endcase
   end

   always_comb begin
      lido = 32'd0;
      for (int i = 0; i < 4; i++) begin
         idx[i]          = src_base + AW'(i);
         lido[8*i +: 8]  = memoria[idx[i]];
      end
   end

   always_comb begin
      resp_dado_d = lido;
      case (src_tamanho)
         2'b00:   resp_dado_d = {{24{src_sinal & lido[7]}}, lido[7:0]};
         2'b01:   resp_dado_d = {{16{src_sinal & lido[15]}}, lido[15:0]};
         default: resp_dado_d = lido;
      endcase
      if (src_escrita || src_erro) begin
         resp_dado_d = 32'd0;
      end
   end

   always_comb begin
      estado_d = estado_q;
      cnt_d    = cnt_q;
      case (estado_q)
         OCIOSO: begin
            if (req_valido) begin
               cnt_d    = 3'(LATENCIA - 1);
               estado_d = (LATENCIA == 1) ? RESPOSTA : ESPERA;
            end
         end
         ESPERA: begin
            cnt_d = cnt_q - 3'd1;
            if (cnt_q <= 3'd1) begin
               estado_d = RESPOSTA;
            end
         end
         RESPOSTA: estado_d = OCIOSO;
         default:  estado_d = OCIOSO;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         estado_q    <= OCIOSO;
         cnt_q       <= 3'd0;
         escrita_q   <= 1'b0;
         tamanho_q   <= 2'b00;
         sinal_q     <= 1'b0;
         base_q      <= '0;
         dado_q      <= 32'd0;
         erro_q      <= 1'b0;
         resp_dado_q <= 32'd0;
         resp_erro_q <= 1'b0;
      end else begin
         estado_q <= estado_d;
         cnt_q    <= cnt_d;
         if (aceita) begin
            escrita_q <= req_escrita;
            tamanho_q <= req_tamanho;
            sinal_q   <= req_sinal;
            base_q    <= req_endereco[AW-1:0];
            dado_q    <= req_dado;
            erro_q    <= erro_in;
         end
         if (commit) begin
            resp_dado_q <= resp_dado_d;
            resp_erro_q <= src_erro;
         end
      end
   end

   // Only the addressed lanes are written, so neighbouring bytes keep their value.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int j = 0; j < PROFUNDIDADE_BYTES; j++) begin
            memoria[j] <= 8'h00;
         end
      end else if (commit && src_escrita && !src_erro) begin
         for (int i = 0; i < 4; i++) begin
            if (2'(i) <= src_off) begin
               memoria[idx[i]] <= src_dado[8*i +: 8];
            end
         end
      end
   end

endmodule
